// File: rtl/tflip.sv
// Toggle flip-flop: an XOR stage computes d = t ^ qp, and a plain D register
// with synchronous active-high reset captures it as qn. Vector form via WIDTH.

module tflip_dreg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

module tflip #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] qp,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] d;

  // Present state comes from outside; the toggle only happens across cycles
  // when the integrator feeds qn back into qp.
  assign d = t ^ qp;

  tflip_dreg #(
    .WIDTH(WIDTH)
  ) u_dreg (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (qn)
  );

endmodule

// File: tb/tb_tflip.sv
// Self-checking bench for tflip: a 1-bit instance (with optional qn->qp
// feedback) and a 4-bit instance, checked through an expected-value queue.

module tb_tflip;

  typedef struct {
    string      name;
    logic       wide;
    logic       reset;
    logic [3:0] t;
    logic [3:0] qp;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic       wide;
    logic [3:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset1, t1, qp1, qn1, qp1_mux;
  logic       fb = 1'b0;
  logic       reset4;
  logic [3:0] t4, qp4, qn4;

  int n_tests = 0;
  int n_fail  = 0;
  sb_t sb[$];

  always #10 clk = ~clk;

  assign qp1_mux = fb ? qn1 : qp1;

  tflip #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .reset(reset1),
    .t    (t1),
    .qp   (qp1_mux),
    .qn   (qn1)
  );

  tflip #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .reset(reset4),
    .t    (t4),
    .qp   (qp4),
    .qn   (qn4)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Pops one expectation per rising edge, sampled 1 unit after the edge.
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.wide) check(e.name, qn4, e.exp);
      else        check(e.name, {3'b000, qn1}, e.exp);
    end
  end

  task automatic expect_next(input string name, input logic wide, input logic [3:0] exp);
    sb_t e;
    e.name = name;
    e.wide = wide;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Drives one vector just after a falling edge and queues its expectation.
  task automatic drive(input vec_t v);
    @(negedge clk);
    if (v.wide) begin
      reset4 = v.reset;
      t4     = v.t;
      qp4    = v.qp;
    end else begin
      reset1 = v.reset;
      t1     = v.t[0];
      qp1    = v.qp[0];
    end
    expect_next(v.name, v.wide, v.exp);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    logic [3:0] exp_wave [5];

    exp_wave[0] = 4'd0; exp_wave[1] = 4'd1; exp_wave[2] = 4'd0;
    exp_wave[3] = 4'd1; exp_wave[4] = 4'd0;

    reset4 = 1'b1; t4 = 4'b0000; qp4 = 4'b0000;

    // Free-running waveform: reset period 8, qp period 16, t rises at 51.
    for (int tm = 0; tm < 100; tm++) begin
      reset1 = ((tm / 4) % 2) == 0;
      qp1    = ((tm / 8) % 2) == 1;
      t1     = (tm >= 51);
      if (((tm + 1) % 20) == 10)
        expect_next($sformatf("wave_edge%0d", tm + 1), 1'b0, exp_wave[(tm + 1 - 10) / 20]);
      #1;
    end

    vecs.push_back('{"tt_t0_qp0",   1'b0, 1'b0, 4'd0, 4'd0, 4'd0});
    vecs.push_back('{"tt_t0_qp1",   1'b0, 1'b0, 4'd0, 4'd1, 4'd1});
    vecs.push_back('{"tt_t1_qp0",   1'b0, 1'b0, 4'd1, 4'd0, 4'd1});
    vecs.push_back('{"tt_t1_qp1",   1'b0, 1'b0, 4'd1, 4'd1, 4'd0});
    vecs.push_back('{"tt_t1_qp0b",  1'b0, 1'b0, 4'd1, 4'd0, 4'd1});
    vecs.push_back('{"rst_prio",    1'b0, 1'b1, 4'd1, 4'd0, 4'd0});
    vecs.push_back('{"w4_rst",      1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{"w4_mix",      1'b1, 1'b0, 4'b1010, 4'b0110, 4'b1100});
    vecs.push_back('{"w4_reset",    1'b1, 1'b1, 4'b1010, 4'b0110, 4'b0000});
    vecs.push_back('{"w4_hold",     1'b1, 1'b0, 4'b0000, 4'b1001, 4'b1001});
    vecs.push_back('{"w4_toggle",   1'b1, 1'b0, 4'b1111, 4'b1001, 4'b0110});
    foreach (vecs[i]) drive(vecs[i]);

    // A reset pulse that misses the edge must not clear qn.
    drive('{"pulse_pre", 1'b0, 1'b0, 4'd1, 4'd0, 4'd1});
    drive('{"pulse_edge", 1'b0, 1'b0, 4'd0, 4'd1, 4'd1});
    #3 reset1 = 1'b1;
    #3 reset1 = 1'b0;
    check("pulse_mid", {3'b000, qn1}, 4'd1);
    drive('{"pulse_held", 1'b0, 1'b1, 4'd0, 4'd1, 4'd0});

    // Feedback loop: qp tied to qn, divide-by-2, then hold with t=0.
    @(negedge clk);
    fb = 1'b1; t1 = 1'b1; reset1 = 1'b1;
    expect_next("fb_reset", 1'b0, 4'd0);
    @(negedge clk);
    reset1 = 1'b0;
    expect_next("fb_tog1", 1'b0, 4'd1);
    @(negedge clk); expect_next("fb_tog2", 1'b0, 4'd0);
    @(negedge clk); expect_next("fb_tog3", 1'b0, 4'd1);
    @(negedge clk); expect_next("fb_tog4", 1'b0, 4'd0);
    @(negedge clk); expect_next("fb_tog5", 1'b0, 4'd1);
    @(negedge clk);
    t1 = 1'b0;
    expect_next("fb_hold1", 1'b0, 4'd1);
    @(negedge clk); expect_next("fb_hold2", 1'b0, 4'd1);

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tflip.md
# tflip

Toggle (T) flip-flop built as a D register with combinational toggle logic in front of it. Present state `qp` is supplied externally; the block registers next state `qn`. Used as a leaf cell in counter and divider chains, where each stage's `qn` is fed back (directly or through other logic) into its own `qp`. Per-bit vector form via `WIDTH`; the default is a single flip-flop.

## Interface
- `WIDTH`, default 1: number of independent T flip-flops in parallel; all ports below are `WIDTH` bits.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high reset; sampled only on rising `clk`.
- `t` input WIDTH: toggle enable per bit; 1 = next state is inverse of `qp`, 0 = next state equals `qp`.
- `qp` input WIDTH: present state supplied by the surrounding logic (normally the fed-back `qn`).
- `qn` output WIDTH: registered next state.

## Operation
- Internal D input per bit: `d[i] = t[i] XOR qp[i]`, purely combinational.
  - t=0, qp=0 -> d=0.
  - t=0, qp=1 -> d=1.
  - t=1, qp=0 -> d=1.
  - t=1, qp=1 -> d=0.
- On every rising `clk` edge:
  - If `reset`=1: `qn` <= all zeros. Reset has priority over `t`/`qp`.
  - Else: `qn` <= `d`.
- Between edges `qn` holds. Changes on `t`, `qp` or `reset` alone never change `qn`; no asynchronous path.
- Bits are fully independent; no carry or interaction between bits.
- `qn` is not fed back internally. The toggle behaviour across cycles relies on the integrator connecting `qn` to `qp`.
- Structure: a separate D-register stage (`d`, `clk`, `reset` -> `q`) instantiated per bit or as a vector, with the XOR stage in front. This keeps the cell reusable as a plain D flip-flop.

## Timing
- Latency: one clock. `qn` after edge k reflects `t`/`qp`/`reset` sampled at edge k.
- Reset value: `qn` = 0 one edge after `reset` is sampled high.
- Before the first rising edge, `qn` is unspecified (X in simulation). Users apply `reset` for at least one edge before relying on `qn`.
- Reset deasserted mid-operation: the first edge with `reset`=0 loads `t ^ qp` normally; no recovery cycles.
- Reset pulses shorter than a clock period that do not cover a rising edge have no effect.
- `t`, `qp` and `reset` must meet setup/hold around the rising edge. Stimulus must not change them coincident with the edge.
- Feedback use (`qp` = `qn`, t=1): `qn` toggles every cycle, giving divide-by-2 of `clk`.

## Test plan
- Free-running 20-unit clock (rising edges at 10, 30, 50, 70, 90) with `reset` toggling every 4 units starting high, `qp` toggling every 8 units starting 0, and `t` toggling every 50 units starting 0, with `t` changes moved off the edge:
  - Edge 10: reset=1 -> `qn`=0.
  - Edge 30: reset=0, t=0, qp=1 -> `qn`=1.
  - Edge 50: reset=1 -> `qn`=0.
  - Edge 70: reset=0, t=1, qp=0 -> `qn`=1.
  - Edge 90: reset=1 -> `qn`=0.
- Truth table with reset=0, one combination per edge:
  - (t,qp) = (0,0) -> `qn`=0.
  - (t,qp) = (0,1) -> `qn`=1.
  - (t,qp) = (1,0) -> `qn`=1.
  - (t,qp) = (1,1) -> `qn`=0.
- Synchronous reset check: `qn`=1, pulse `reset` high between edges and drop it before the next edge -> `qn` stays 1. Holding `reset` across an edge -> `qn`=0 at that edge.
- Reset priority: reset=1 with t=1, qp=0 at an edge -> `qn`=0, not 1.
- Feedback loop: tie `qp` to `qn`, t=1, reset for one edge, then release -> `qn` sequence 0,1,0,1,… one toggle per edge. Then set t=0 -> `qn` holds its current value.
- `WIDTH`=4: t=4'b1010, qp=4'b0110, reset=0 -> `qn`=4'b1100 after one edge. Assert reset -> `qn`=4'b0000.
